ntt_result_collector: RTL and testbench
=======================================

// Module: ntt_result_collector
// PURPOSE
//  Receive side of the NTT evaluation result stream. Captures the serial
//  coefficient stream (one WIDTH-bit word per cycle, word 0 flagged by a
//  one-cycle done pulse) into an N_WORDS-deep buffer. Exposes the buffer
//  through a 1-cycle-latency addressed read port, so a host/test harness can
//  collect NTT results produced by the evaluation wrapper.
// PARAMETERS
//  N_WORDS  257  words per result frame (NTT length)
//  WIDTH    32   coefficient word width
//  AW       9    read address width; must satisfy 2**AW >= N_WORDS
// PORTS
//  clk      in   1      rising-edge clock, only clock
//  reset    in   1      synchronous, active-low reset
//  done_in  in   1      frame-start pulse; dout_in carries word 0 in the same cycle
//  dout_in  in   WIDTH  serial result word; word k arrives k cycles after done_in
//  clear    in   1      drops frame_ready and overrun; buffer contents are kept
//  rd_en    in   1      read request
//  rd_addr  in   AW     word index to read
//  rd_data  out  WIDTH  read data, valid when rd_valid=1
//  rd_valid out  1      high exactly 1 cycle after an rd_en cycle
//  busy     out  1      high while a capture is in progress
//  frame_ready out 1    sticky; set when word N_WORDS-1 is stored
//  overrun  out  1      sticky; set when done_in starts a new frame over an unread or incomplete one
// BEHAVIOUR
//  - Reset (reset=0 at a clk edge): state=IDLE; wr_cnt, rd_data, rd_valid,
//    busy, frame_ready, overrun (and checksum, if enabled) all 0.
//    Buffer contents are undefined. Reset dominates all other inputs.
//  - FSM states: IDLE, CAPTURE, HOLD.
//    * IDLE -> CAPTURE on done_in=1: store dout_in at index 0, wr_cnt<=1, busy<=1.
//    * CAPTURE: each cycle store dout_in at index wr_cnt, then wr_cnt++.
//      No gaps are tolerated: one word is taken every cycle.
//      On the store of index N_WORDS-1: go to HOLD, busy<=0, frame_ready<=1.
//    * HOLD: ignore dout_in. done_in=1 restarts capture exactly as from IDLE.
//  - Whole-frame latency: frame_ready rises N_WORDS cycles after the done_in
//    cycle (the edge that stores the last word).
//  - done_in during CAPTURE or HOLD: restart at index 0 and set overrun<=1.
//    Exception: a restart from HOLD after clear with no intervening frame
//    does not set overrun (frame_ready was 0).
//    Any restart also sets frame_ready<=0.
//  - clear: frame_ready<=0 and overrun<=0. If done_in is high in the same
//    cycle, done_in wins: capture restarts and overrun is evaluated first,
//    so clear wins only for the flag values.
//  - Read port: on rd_en, rd_data<=buf[rd_addr] at the next edge, and
//    rd_valid is high for 1 cycle.
//    * rd_addr >= N_WORDS: rd_data=0, rd_valid still pulses.
//    * Reads are legal in any state. During CAPTURE a read returns the
//      present buffer word (old or new frame); no stall.
//    * Read and write of the same index in the same cycle returns the old
//      value.
//    * When rd_en=0, rd_data holds its last value.
//  - wr_cnt is AW bits wide and never exceeds N_WORDS-1. There is no
//    wrap-around writing.
// CONFIGURATION
//  NTT_COLLECT_CHECKSUM_EN defined:
//    * Adds output checksum (WIDTH bits): running sum mod 2**WIDTH of every
//      word stored in the current frame.
//    * Zeroed on reset and on every frame start. On a frame start the
//      checksum is loaded with word 0.
//    * Stable in HOLD.
//  NTT_COLLECT_CHECKSUM_EN not defined: no checksum port and no adder
//  logic; all other behaviour is identical.
// TESTING
//  1 Reset: hold reset=0 for 3 cycles with done_in=1 -> all outputs 0,
//    busy stays 0.
//  2 Full frame: done_in pulse with dout_in=k+100 for k=0..256 ->
//    frame_ready rises 257 cycles after the pulse; reading addr 0, 128, 256
//    gives 100, 228, 356, with rd_valid one cycle after rd_en.
//  3 Restart mid-frame: second done_in at word 50 -> overrun=1,
//    frame_ready=0; frame completes 257 cycles after the second pulse with
//    the new data at addr 0..256.
//  4 Clear with done_in: in HOLD, assert clear and done_in together ->
//    busy=1, overrun=0, frame_ready=0.
//  5 Read out of range: rd_addr=300 -> rd_data=0, rd_valid=1.
//    Same-cycle read/write of index 5 during capture returns the old value.
//  6 Checksum (macro on): frame of all 0xFFFFFFFF words -> checksum =
//    257*0xFFFFFFFF mod 2**32 = 0xFFFFFEFF.

Source files
------------

// File: rtl/ntt_result_collector_if.sv
// Bundles the NTT result stream, control, read port and status of ntt_result_collector.
// Define NTT_COLLECT_CHECKSUM_EN to add the checksum status word.
interface ntt_result_collector_if #(
    parameter int unsigned WIDTH = 32,
    parameter int unsigned AW    = 9
);
    logic             done_in;
    logic [WIDTH-1:0] dout_in;
    logic             clear;
    logic             rd_en;
    logic [AW-1:0]    rd_addr;
    logic [WIDTH-1:0] rd_data;
    logic             rd_valid;
    logic             busy;
    logic             frame_ready;
    logic             overrun;
`ifdef NTT_COLLECT_CHECKSUM_EN
    logic [WIDTH-1:0] checksum;

    modport master (
        output done_in, dout_in, clear, rd_en, rd_addr,
        input  rd_data, rd_valid, busy, frame_ready, overrun, checksum
    );
    modport slave (
        input  done_in, dout_in, clear, rd_en, rd_addr,
        output rd_data, rd_valid, busy, frame_ready, overrun, checksum
    );
`else
    modport master (
        output done_in, dout_in, clear, rd_en, rd_addr,
        input  rd_data, rd_valid, busy, frame_ready, overrun
    );
    modport slave (
        input  done_in, dout_in, clear, rd_en, rd_addr,
        output rd_data, rd_valid, busy, frame_ready, overrun
    );
`endif
endinterface

// File: rtl/ntt_result_collector.sv
// Captures one serial NTT result frame into a buffer and serves it through a 1-cycle read port.
// Define NTT_COLLECT_CHECKSUM_EN to add a running mod-2**WIDTH checksum of the captured frame.
module ntt_result_collector #(
    parameter int unsigned N_WORDS = 257,
    parameter int unsigned WIDTH   = 32,
    parameter int unsigned AW      = 9
) (
    input logic                   clk,
    input logic                   reset,
    ntt_result_collector_if.slave bus
);
    localparam logic [AW-1:0] LastIdx = AW'(N_WORDS - 1);

    typedef enum logic [1:0] {StIdle, StCapture, StHold} state_e;

    state_e           state_q, state_d;
    logic [AW-1:0]    wr_cnt_q, wr_cnt_d;
    logic             busy_q, busy_d;
    logic             frame_ready_q, frame_ready_d;
    logic             overrun_q, overrun_d;
    logic [WIDTH-1:0] rd_data_q;
    logic             rd_valid_q;
    logic             wr_en;
    logic [AW-1:0]    wr_idx;
    logic             start;
    logic             last_word;
    logic             overrun_set;
    logic [WIDTH-1:0] mem_q [N_WORDS];
`ifdef NTT_COLLECT_CHECKSUM_EN
    logic [WIDTH-1:0] checksum_q, checksum_d;
`endif

    assign start     = bus.done_in;
    assign last_word = (state_q == StCapture) && !start && (wr_cnt_q == LastIdx);
    // A restart only counts as an overrun if a frame was in flight or completed and unread.
    assign overrun_set = start && ((state_q == StCapture) || ((state_q == StHold) && frame_ready_q));

    always_ff @(posedge clk) begin : p_state
        if (!reset) begin
            state_q       <= StIdle;
            wr_cnt_q      <= '0;
            busy_q        <= 1'b0;
            frame_ready_q <= 1'b0;
            overrun_q     <= 1'b0;
`ifdef NTT_COLLECT_CHECKSUM_EN
            checksum_q    <= '0;
`endif
        end else begin
            state_q       <= state_d;
            wr_cnt_q      <= wr_cnt_d;
            busy_q        <= busy_d;
            frame_ready_q <= frame_ready_d;
            overrun_q     <= overrun_d;
`ifdef NTT_COLLECT_CHECKSUM_EN
            checksum_q    <= checksum_d;
`endif
        end
    end

    always_comb begin : p_next_state
        state_d = state_q;
        unique case (state_q)
            StIdle:    if (start) state_d = StCapture;
            StCapture: if (last_word) state_d = StHold;
            StHold:    if (start) state_d = StCapture;
            default:   state_d = StIdle;
        endcase
    end

    always_comb begin : p_outputs
        wr_en         = 1'b0;
        wr_idx        = wr_cnt_q;
        wr_cnt_d      = wr_cnt_q;
        busy_d        = busy_q;
        frame_ready_d = frame_ready_q & ~bus.clear;
        overrun_d     = bus.clear ? 1'b0 : (overrun_q | overrun_set);
`ifdef NTT_COLLECT_CHECKSUM_EN
        checksum_d    = checksum_q;
`endif
        if (start) begin
            wr_en         = 1'b1;
            wr_idx        = '0;
            wr_cnt_d      = AW'(1);
            busy_d        = 1'b1;
            frame_ready_d = 1'b0;
`ifdef NTT_COLLECT_CHECKSUM_EN
            checksum_d    = bus.dout_in;
`endif
        end else if (state_q == StCapture) begin
            wr_en = 1'b1;
`ifdef NTT_COLLECT_CHECKSUM_EN
            checksum_d = checksum_q + bus.dout_in;
`endif
            if (last_word) begin
                busy_d        = 1'b0;
                frame_ready_d = 1'b1;
            end else begin
                wr_cnt_d = wr_cnt_q + AW'(1);
            end
        end
    end

    always_ff @(posedge clk) begin : p_mem_wr
        if (reset && wr_en) begin
            mem_q[wr_idx] <= bus.dout_in;
        end
    end

    // Non-blocking read of mem_q gives the pre-write word on a same-index collision.
    always_ff @(posedge clk) begin : p_read
        if (!reset) begin
            rd_data_q  <= '0;
            rd_valid_q <= 1'b0;
        end else begin
            rd_valid_q <= bus.rd_en;
            if (bus.rd_en) begin
                rd_data_q <= (bus.rd_addr <= LastIdx) ? mem_q[bus.rd_addr] : '0;
            end
        end
    end

    assign bus.rd_data     = rd_data_q;
    assign bus.rd_valid    = rd_valid_q;
    assign bus.busy        = busy_q;
    assign bus.frame_ready = frame_ready_q;
    assign bus.overrun     = overrun_q;
`ifdef NTT_COLLECT_CHECKSUM_EN
    assign bus.checksum    = checksum_q;
`endif
endmodule

// File: tb/tb_ntt_result_collector.sv
// Directed self-checking bench for ntt_result_collector (N_WORDS=257, WIDTH=32, AW=9).
module tb_ntt_result_collector;
    logic clk = 1'b0;
    logic reset;
    int   checks = 0;
    int   errors = 0;

    always #5 clk = ~clk;

    ntt_result_collector_if #(.WIDTH(32), .AW(9)) bus ();

    ntt_result_collector #(.N_WORDS(257), .WIDTH(32), .AW(9)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic feed(input int from, input int to, input logic [31:0] base);
        for (int k = from; k <= to; k++) begin
            bus.dout_in = base + 32'(k);
            tick();
        end
    endtask

    task automatic test_reset();
        reset = 1'b0; bus.done_in = 1'b1; bus.dout_in = 32'hAA; bus.clear = 1'b0;
        bus.rd_en = 1'b1; bus.rd_addr = 9'd0;
        for (int i = 0; i < 3; i++) begin
            tick();
            checks++;
            if (bus.busy !== 1'b0) begin
                errors++; $display("FAIL reset_busy cyc %0d got %b want 0", i, bus.busy);
            end
        end
        checks++;
        if (bus.rd_data !== 32'd0 || bus.rd_valid !== 1'b0 || bus.frame_ready !== 1'b0 ||
            bus.overrun !== 1'b0) begin
            errors++;
            $display("FAIL reset_outputs got data=%h valid=%b ready=%b ovr=%b want all 0",
                     bus.rd_data, bus.rd_valid, bus.frame_ready, bus.overrun);
        end
`ifdef NTT_COLLECT_CHECKSUM_EN
        checks++;
        if (bus.checksum !== 32'd0) begin
            errors++; $display("FAIL reset_checksum got %h want 0", bus.checksum);
        end
`endif
        bus.done_in = 1'b0; bus.rd_en = 1'b0;
        reset = 1'b1;
        tick();
        checks++;
        if (bus.busy !== 1'b0) begin
            errors++; $display("FAIL idle_busy got %b want 0", bus.busy);
        end
    endtask

    task automatic test_full_frame();
        int unsigned addrs [3] = '{0, 128, 256};
        logic [31:0] exp   [3] = '{32'd100, 32'd228, 32'd356};
        bus.done_in = 1'b1; bus.dout_in = 32'd100;
        tick();
        bus.done_in = 1'b0;
        checks++;
        if (bus.busy !== 1'b1) begin
            errors++; $display("FAIL frame_busy got %b want 1", bus.busy);
        end
        for (int k = 1; k <= 256; k++) begin
            bus.dout_in = 32'd100 + 32'(k);
            tick();
            checks++;
            if (bus.frame_ready !== (k == 256) || bus.busy !== (k != 256)) begin
                errors++;
                $display("FAIL frame_latency word %0d got ready=%b busy=%b want ready=%b",
                         k, bus.frame_ready, bus.busy, (k == 256));
            end
        end
        bus.dout_in = 32'hDEADBEEF;
        tick();
        for (int i = 0; i < 3; i++) begin
            bus.rd_en = 1'b1; bus.rd_addr = 9'(addrs[i]);
            tick();
            bus.rd_en = 1'b0;
            checks++;
            if (bus.rd_valid !== 1'b1 || bus.rd_data !== exp[i]) begin
                errors++;
                $display("FAIL frame_read addr %0d got %h valid=%b want %h valid=1",
                         addrs[i], bus.rd_data, bus.rd_valid, exp[i]);
            end
            tick();
            checks++;
            if (bus.rd_valid !== 1'b0 || bus.rd_data !== exp[i]) begin
                errors++;
                $display("FAIL read_hold addr %0d got %h valid=%b want %h valid=0",
                         addrs[i], bus.rd_data, bus.rd_valid, exp[i]);
            end
        end
    endtask

    task automatic test_hold_restart();
        bus.done_in = 1'b1; bus.dout_in = 32'd3000;
        tick();
        bus.done_in = 1'b0;
        checks++;
        if (bus.overrun !== 1'b1 || bus.frame_ready !== 1'b0 || bus.busy !== 1'b1) begin
            errors++;
            $display("FAIL hold_restart got ovr=%b ready=%b busy=%b want 1 0 1",
                     bus.overrun, bus.frame_ready, bus.busy);
        end
        feed(1, 256, 32'd3000);
        checks++;
        if (bus.frame_ready !== 1'b1 || bus.busy !== 1'b0 || bus.overrun !== 1'b1) begin
            errors++;
            $display("FAIL hold_restart_done got ready=%b busy=%b ovr=%b want 1 0 1",
                     bus.frame_ready, bus.busy, bus.overrun);
        end
    endtask

    task automatic test_restart_mid_frame();
        int unsigned addrs [4] = '{0, 49, 50, 256};
        logic [31:0] exp   [4] = '{32'd2000, 32'd2049, 32'd2050, 32'd2256};
        bus.clear = 1'b1;
        tick();
        bus.clear = 1'b0;
        checks++;
        if (bus.frame_ready !== 1'b0 || bus.overrun !== 1'b0) begin
            errors++;
            $display("FAIL clear got ready=%b ovr=%b want 0 0", bus.frame_ready, bus.overrun);
        end
        bus.done_in = 1'b1; bus.dout_in = 32'd1000;
        tick();
        bus.done_in = 1'b0;
        checks++;
        if (bus.overrun !== 1'b0 || bus.busy !== 1'b1) begin
            errors++;
            $display("FAIL restart_after_clear got ovr=%b busy=%b want 0 1", bus.overrun, bus.busy);
        end
        feed(1, 49, 32'd1000);
        bus.done_in = 1'b1; bus.dout_in = 32'd2000;
        tick();
        bus.done_in = 1'b0;
        checks++;
        if (bus.overrun !== 1'b1 || bus.frame_ready !== 1'b0 || bus.busy !== 1'b1) begin
            errors++;
            $display("FAIL restart_mid got ovr=%b ready=%b busy=%b want 1 0 1",
                     bus.overrun, bus.frame_ready, bus.busy);
        end
        feed(1, 255, 32'd2000);
        checks++;
        if (bus.frame_ready !== 1'b0) begin
            errors++; $display("FAIL restart_early_ready got %b want 0", bus.frame_ready);
        end
        feed(256, 256, 32'd2000);
        checks++;
        if (bus.frame_ready !== 1'b1 || bus.busy !== 1'b0) begin
            errors++;
            $display("FAIL restart_ready got ready=%b busy=%b want 1 0", bus.frame_ready, bus.busy);
        end
        for (int i = 0; i < 4; i++) begin
            bus.rd_en = 1'b1; bus.rd_addr = 9'(addrs[i]);
            tick();
            checks++;
            if (bus.rd_valid !== 1'b1 || bus.rd_data !== exp[i]) begin
                errors++;
                $display("FAIL restart_read addr %0d got %h valid=%b want %h valid=1",
                         addrs[i], bus.rd_data, bus.rd_valid, exp[i]);
            end
        end
        bus.rd_en = 1'b0;
    endtask

    task automatic test_clear_with_done();
        bus.clear = 1'b1; bus.done_in = 1'b1; bus.dout_in = 32'd5000;
        tick();
        bus.clear = 1'b0; bus.done_in = 1'b0;
        checks++;
        if (bus.busy !== 1'b1 || bus.overrun !== 1'b0 || bus.frame_ready !== 1'b0) begin
            errors++;
            $display("FAIL clear_done got busy=%b ovr=%b ready=%b want 1 0 0",
                     bus.busy, bus.overrun, bus.frame_ready);
        end
        for (int k = 1; k <= 256; k++) begin
            bus.dout_in = 32'd5000 + 32'(k);
            bus.rd_en   = (k == 5);
            bus.rd_addr = 9'd5;
            tick();
            if (k == 5) begin
                checks++;
                if (bus.rd_valid !== 1'b1 || bus.rd_data !== 32'd2005) begin
                    errors++;
                    $display("FAIL rw_collision got %h valid=%b want %h valid=1",
                             bus.rd_data, bus.rd_valid, 32'd2005);
                end
            end
        end
        bus.rd_en = 1'b0;
        checks++;
        if (bus.frame_ready !== 1'b1 || bus.overrun !== 1'b0) begin
            errors++;
            $display("FAIL clear_done_end got ready=%b ovr=%b want 1 0", bus.frame_ready, bus.overrun);
        end
    endtask

    task automatic test_read_range();
        bus.rd_en = 1'b1; bus.rd_addr = 9'd300;
        tick();
        checks++;
        if (bus.rd_valid !== 1'b1 || bus.rd_data !== 32'd0) begin
            errors++;
            $display("FAIL read_oor got %h valid=%b want 0 valid=1", bus.rd_data, bus.rd_valid);
        end
        bus.rd_addr = 9'd5;
        tick();
        checks++;
        if (bus.rd_valid !== 1'b1 || bus.rd_data !== 32'd5005) begin
            errors++;
            $display("FAIL read_new got %h valid=%b want %h valid=1",
                     bus.rd_data, bus.rd_valid, 32'd5005);
        end
        bus.rd_addr = 9'd257;
        tick();
        bus.rd_en = 1'b0;
        checks++;
        if (bus.rd_data !== 32'd0) begin
            errors++; $display("FAIL read_oor_edge got %h want 0", bus.rd_data);
        end
    endtask

`ifdef NTT_COLLECT_CHECKSUM_EN
    task automatic test_checksum();
        bus.clear = 1'b1;
        tick();
        bus.clear = 1'b0;
        bus.done_in = 1'b1; bus.dout_in = 32'hFFFFFFFF;
        tick();
        bus.done_in = 1'b0;
        checks++;
        if (bus.checksum !== 32'hFFFFFFFF || bus.overrun !== 1'b0) begin
            errors++;
            $display("FAIL checksum_start got %h ovr=%b want ffffffff 0", bus.checksum, bus.overrun);
        end
        for (int k = 1; k <= 256; k++) tick();
        checks++;
        if (bus.checksum !== 32'hFFFFFEFF || bus.frame_ready !== 1'b1) begin
            errors++;
            $display("FAIL checksum_frame got %h ready=%b want fffffeff 1",
                     bus.checksum, bus.frame_ready);
        end
        bus.dout_in = 32'd1;
        tick();
        tick();
        checks++;
        if (bus.checksum !== 32'hFFFFFEFF) begin
            errors++; $display("FAIL checksum_hold got %h want fffffeff", bus.checksum);
        end
    endtask
`endif

    initial begin
        test_reset();
        test_full_frame();
        test_hold_restart();
        test_restart_mid_frame();
        test_clear_with_done();
        test_read_range();
`ifdef NTT_COLLECT_CHECKSUM_EN
        test_checksum();
`endif
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
